masked_sbox_layer: RTL
======================

Name: masked_sbox_layer

Overview:
- Parametrised, pipelined layer of N_LANES two-share (first-order, GLM) PRINCE S-boxes.
- Each transaction selects forward or inverse S-box mode.
- Valid/ready handshake with backpressure; every load requires fresh randomness.
- Sits between the masked state register and the masked M-layer of the round-based masked PRINCE datapath.

Parameters:
- N_LANES, 16, number of parallel 4-bit S-box lanes (1..16).
- R_BITS, 36, randomness bits per lane per core.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of all pipeline valids.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  layer can accept an input this cycle.
- in_mode  in  1  0 = forward S-box, 1 = inverse S-box.
- in_x  in  4*N_LANES  share 0; lane i occupies bits [4i+3:4i].
- in_y  in  4*N_LANES  share 1, same packing as in_x.
- rnd  in  R_BITS*N_LANES  fresh randomness; lane i occupies bits [R_BITS*i+R_BITS-1:R_BITS*i].
- rnd_valid  in  1  rnd is fresh this cycle.
- out_valid  out  1  output transaction valid.
- out_ready  in  1  downstream accepts the output.
- out_mode  out  1  mode carried with the transaction.
- out_x  out  4*N_LANES  result share 0.
- out_y  out  4*N_LANES  result share 1.
- busy  out  1  any pipeline stage holds a valid transaction.

Behaviour:
- Unmasked function per lane: out_x^out_y = S(in_x^in_y).
  - Forward S: 0→B, 1→F, 2→3, 3→2, 4→A, 5→C, 6→9, 7→1, 8→6, 9→7, A→8, B→0, C→E, D→5, E→D, F→4.
  - Inverse S: 0→B, 1→7, 2→3, 3→2, 4→F, 5→D, 6→8, 7→9, 8→A, 9→6, A→4, B→0, C→5, D→E, E→C, F→1.
- Per-lane structure:
  - One forward and one inverse two-share GLM core, each with one internal register stage.
  - Both cores receive the lane's rnd slice.
  - Only the selected core's register enable is asserted.
  - The unselected core's share inputs are forced to 0, so no unused masked data toggles.
- Stage A (core registers + mode_a, valid_a):
  - Loads when load_a = in_valid & in_ready.
- Stage B (output share registers out_x/out_y + out_mode, valid_b):
  - Loads when adv_b = valid_a & ready_b.
  - out_x/out_y take the mux of the registered core shares selected by mode_a.
  - No combinational recombination of shares across lanes or stages.
- Ready chain, with no combinational path from out_ready to in_valid:
  - ready_b = ~valid_b | out_ready.
  - ready_a = ~valid_a | ready_b.
  - in_ready = ready_a & rnd_valid & ~flush.
- Latency: 2 cycles from accepted input to out_valid when out_ready is held high. Throughput: 1 transaction per cycle.
- Backpressure: with out_valid=1 and out_ready=0, out_x, out_y and out_mode hold stable. Stage A also holds, and its core register enables are deasserted.
- rnd_valid=0 blocks acceptance only; transactions already in flight keep draining.
- Simultaneous accept and drain: stage B is overwritten in the same cycle its old contents are consumed; no bubble is inserted.
- flush:
  - Clears valid_a and valid_b on the next edge; data registers are left untouched.
  - in_ready is 0 during flush.
  - flush has priority over a simultaneous accept.
- Reset (asynchronous, active-low):
  - All share registers, mode registers and valids go to 0.
  - out_valid=0, out_mode=0, out_x=0, out_y=0, busy=0.
  - in_ready = rnd_valid once rst is released.
  - Reset asserted mid-transaction discards all in-flight data.
- busy = valid_a | valid_b.

Test Plan:
- N_LANES=1, forward, x=5, y=5 (value 0), rnd random, out_ready=1 → out_valid at cycle +2, out_x^out_y=B, out_mode=0.
- Inverse, x=3, y=8 (value B) → out_x^out_y=0. Exhaustive sweep of 16 values × 2 modes × random shares matches both tables.
- Default N_LANES=16, back-to-back stream of 20 transactions with alternating mode → one result per cycle, in order, all lanes correct.
- Hold out_ready=0 for 5 cycles with 3 transactions offered → in_ready drops after 2 accepts. Outputs stay stable. All 3 results emerge unchanged after release.
- rnd_valid=0 with in_valid=1 → in_ready=0, nothing accepted. Transactions already in flight still complete.
- flush asserted with 2 transactions in flight, and rst pulsed low mid-stream → out_valid=0 next cycle, busy=0. After rst, all outputs read 0 and the next accepted input produces a correct result.

Source files
------------

// File: rtl/masked_sbox_layer.sv
// rtl/masked_sbox_layer.sv - pipelined layer of two-share PRINCE S-boxes, forward or inverse per transaction
// Each lane carries a forward and an inverse masked core; only the selected core is fed and clocked.

module masked_sbox_core #(
  parameter bit INVERSE = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [3:0]  a,
  input  logic [3:0]  b,
  input  logic [35:0] r,
  output logic [3:0]  s0,
  output logic [3:0]  s1
);

  function automatic logic [3:0] sbox(input logic [3:0] v);
    logic [3:0] f;
    f = 4'h0;
    if (!INVERSE) begin
      case (v)
        4'h0: f = 4'hB;  4'h1: f = 4'hF;  4'h2: f = 4'h3;  4'h3: f = 4'h2;
        4'h4: f = 4'hA;  4'h5: f = 4'hC;  4'h6: f = 4'h9;  4'h7: f = 4'h1;
        4'h8: f = 4'h6;  4'h9: f = 4'h7;  4'hA: f = 4'h8;  4'hB: f = 4'h0;
        4'hC: f = 4'hE;  4'hD: f = 4'h5;  4'hE: f = 4'hD;  default: f = 4'h4;
      endcase
    end else begin
      case (v)
        4'h0: f = 4'hB;  4'h1: f = 4'h7;  4'h2: f = 4'h3;  4'h3: f = 4'h2;
        4'h4: f = 4'hF;  4'h5: f = 4'hD;  4'h6: f = 4'h8;  4'h7: f = 4'h9;
        4'h8: f = 4'hA;  4'h9: f = 4'h6;  4'hA: f = 4'h4;  4'hB: f = 4'h0;
        4'hC: f = 4'h5;  4'hD: f = 4'hE;  4'hE: f = 4'hC;  default: f = 4'h1;
      endcase
    end
    return f;
  endfunction

  // Algebraic normal form of output bit j (Moebius transform of its truth table).
  function automatic logic [15:0] anf(input int j);
    logic [15:0] t;
    logic [3:0]  s;
    t = 16'h0;
    for (int v = 0; v < 16; v++) begin
      s = sbox(4'(v));
      t[v] = s[j];
    end
    for (int i = 0; i < 4; i++)
      for (int m = 0; m < 16; m++)
        if (m[i]) t[m] = t[m] ^ t[m & ~(1 << i)];
    return t;
  endfunction

  localparam logic [63:0] ANF = {anf(3), anf(2), anf(1), anf(0)};

  logic [3:0] dom  [16];
  logic [3:0] msk  [16];
  logic [3:0] dreg [16];
  logic       term;

  // Domain c takes input bit i from share b when c[i]=1, else from share a, so no
  // domain sees both shares of any bit. Each monomial/share pairing lands in exactly
  // one domain: the one whose bits outside the monomial select share a.
  always_comb begin
    term = 1'b0;
    for (int c = 0; c < 16; c++) begin
      dom[c] = 4'h0;
      for (int j = 0; j < 4; j++) begin
        for (int m = 0; m < 16; m++) begin
          if (ANF[16*j+m] && ((c & ~m & 15) == 0)) begin
            term = 1'b1;
            for (int i = 0; i < 4; i++)
              if (m[i]) term = term & (c[i] ? b[i] : a[i]);
            dom[c][j] = dom[c][j] ^ term;
          end
        end
      end
    end
  end

  // Each random nibble enters once per output share, so masks cancel only on recombination.
  always_comb begin
    for (int c = 0; c < 16; c++)
      msk[c] = r[4*(c%8) +: 4];
    msk[0]  = msk[0]  ^ r[35:32];
    msk[15] = msk[15] ^ r[35:32];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < 16; c++) dreg[c] <= 4'h0;
    end else if (en) begin
      for (int c = 0; c < 16; c++) dreg[c] <= dom[c] ^ msk[c];
    end
  end

  always_comb begin
    s0 = 4'h0;
    s1 = 4'h0;
    for (int c = 0; c < 8; c++) begin
      s0 = s0 ^ dreg[c];
      s1 = s1 ^ dreg[c+8];
    end
  end

endmodule

module masked_sbox_layer #(
  parameter int N_LANES = 16,
  parameter int R_BITS  = 36
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_mode,
  input  logic [4*N_LANES-1:0]    in_x,
  input  logic [4*N_LANES-1:0]    in_y,
  input  logic [R_BITS*N_LANES-1:0] rnd,
  input  logic                    rnd_valid,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_mode,
  output logic [4*N_LANES-1:0]    out_x,
  output logic [4*N_LANES-1:0]    out_y,
  output logic                    busy
);

  localparam int W = 4*N_LANES;

  logic         valid_a, mode_a, valid_b;
  logic         ready_a, ready_b, load_a, adv_b;
  logic [W-1:0] fwd_s0, fwd_s1, inv_s0, inv_s1;

  assign ready_b   = ~valid_b | out_ready;
  assign ready_a   = ~valid_a | ready_b;
  assign in_ready  = ready_a & rnd_valid & ~flush;
  assign load_a    = in_valid & in_ready;
  assign adv_b     = valid_a & ready_b;
  assign out_valid = valid_b;
  assign busy      = valid_a | valid_b;

  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    logic [3:0] fa, fb, ia, ib;

    assign fa = in_mode ? 4'h0 : in_x[4*i +: 4];
    assign fb = in_mode ? 4'h0 : in_y[4*i +: 4];
    assign ia = in_mode ? in_x[4*i +: 4] : 4'h0;
    assign ib = in_mode ? in_y[4*i +: 4] : 4'h0;

    masked_sbox_core #(.INVERSE(1'b0)) u_fwd (
      .clk (clk),
      .rst (rst),
      .en  (load_a & ~in_mode),
      .a   (fa),
      .b   (fb),
      .r   (rnd[R_BITS*i +: 36]),
      .s0  (fwd_s0[4*i +: 4]),
      .s1  (fwd_s1[4*i +: 4])
    );

    masked_sbox_core #(.INVERSE(1'b1)) u_inv (
      .clk (clk),
      .rst (rst),
      .en  (load_a & in_mode),
      .a   (ia),
      .b   (ib),
      .r   (rnd[R_BITS*i +: 36]),
      .s0  (inv_s0[4*i +: 4]),
      .s1  (inv_s1[4*i +: 4])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_a <= 1'b0;
      mode_a  <= 1'b0;
    end else begin
      if (flush)       valid_a <= 1'b0;
      else if (load_a) valid_a <= 1'b1;
      else if (adv_b)  valid_a <= 1'b0;
      if (load_a) mode_a <= in_mode;
    end
  end

  // Stage B overwrites in the same cycle its old contents drain, so no bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_b  <= 1'b0;
      out_mode <= 1'b0;
      out_x    <= '0;
      out_y    <= '0;
    end else begin
      if (flush)          valid_b <= 1'b0;
      else if (adv_b)     valid_b <= 1'b1;
      else if (out_ready) valid_b <= 1'b0;
      if (adv_b && !flush) begin
        out_mode <= mode_a;
        out_x    <= mode_a ? inv_s0 : fwd_s0;
        out_y    <= mode_a ? inv_s1 : fwd_s1;
      end
    end
  end

endmodule
